// File: rtl/cpu_ctrl.sv
// Instruction register, decoder and Moore control FSM that sequences the
// register-file/ALU datapath for the MOV/ADD/CMP/AND/MVN instruction set.
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WRITE
    } state_t;

    state_t      state;
    logic [15:0] ir;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign datapath_in = {{8{ir[7]}}, ir[7:0]};

    // IR only captures in WAIT, so a simultaneous load+start executes the new word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_mov_imm)      state <= S_WIMM;
                    else if (is_mov_reg) state <= S_GETB;
                    else if (is_alu)     state <= S_GETA;
                    else                 state <= S_WAIT;
                end
                S_GETA:  state <= S_GETB;
                S_GETB:  state <= S_EXEC;
                S_EXEC:  state <= is_cmp ? S_WAIT : S_WRITE;
                S_WIMM:  state <= S_WAIT;
                S_WRITE: state <= S_WAIT;
                default: state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        w        = 1'b0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        shift    = 2'd0;
        ALUop    = 2'd0;
        case (state)
            S_WAIT: w = 1'b1;
            S_WIMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through the ALU as 0 + B.
                shift = sh;
                ALUop = is_alu ? op : 2'b00;
                asel  = is_mov_reg;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            S_WRITE: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL be clocked by one clock; reset is asynchronous and active-low; port names: clk, reset_n.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- in  in  16  instruction word
- load  in  1  instruction-register load request
- s  in  1  start-execution request
- w  out  1  idle/waiting flag
- write  out  1  register-file write enable
- vsel  out  1  writeback source select (1=datapath_in, 0=C)
- loada, loadb, loadc, loads  out  1 each  A/B/C/status load enables
- asel, bsel  out  1 each  A-zero select / imm5 select
- readnum, writenum  out  3 each  register indices
- shift, ALUop  out  2 each  shifter and ALU op codes
- datapath_in  out  16  sign-extended immediate to datapath

Function
REQ-003 IR (16b) SHALL load `in` on the rising edge when load=1 and FSM is in WAIT; load is ignored in every other state.
REQ-004 Decode fields SHALL be: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
REQ-005 datapath_in SHALL always equal {{8{IR[7]}},IR[7:0]} (sximm8).
REQ-006 Supported instructions SHALL be: MOV imm (110/10), MOV reg (110/00), ADD (101/00), CMP (101/01), AND (101/10), MVN (101/11).
REQ-007 FSM states SHALL be WAIT, DECODE, WIMM, GETA, GETB, EXEC, WRITE.
REQ-008 Transitions SHALL be:
- WAIT -> DECODE if s=1, else stay.
- DECODE -> WIMM (MOV imm), GETB (MOV reg), GETA (ALU class), WAIT (any other encoding).
- GETA -> GETB.
- GETB -> EXEC.
- EXEC -> WAIT (CMP), else WRITE.
- WIMM -> WAIT; WRITE -> WAIT.
REQ-009 Outputs SHALL be Moore, combinational from state and IR; every control not listed for a state SHALL be 0 (readnum/writenum/shift/ALUop = 0).
REQ-010 Output assertions per state SHALL be:
- WAIT: w=1.
- WIMM: writenum=Rn, vsel=1, write=1.
- GETA: readnum=Rn, loada=1.
- GETB: readnum=Rm, loadb=1.
- EXEC: shift=sh; ALUop=op for ALU class, 00 for MOV reg; asel=1 for MOV reg only; bsel=0; loads=1 for CMP, else loadc=1.
- WRITE: writenum=Rd, vsel=0, write=1.
REQ-011 Latency from the edge sampling s=1 to w returning high SHALL be: MOV imm 3, MOV reg 4, CMP 4, ADD/AND/MVN 5 cycles.
REQ-012 s=1 and load=1 in the same WAIT cycle SHALL load IR and execute the newly loaded instruction.
REQ-013 s held high SHALL re-execute the IR contents back-to-back, re-entering DECODE on the cycle after WAIT.
REQ-014 An unsupported encoding SHALL return to WAIT after DECODE with no write/load enable asserted.
REQ-015 s while not in WAIT SHALL be ignored.

Reset
REQ-016 reset_n=0 SHALL immediately force state=WAIT and IR=0, independent of clk.
REQ-017 Under reset, outputs SHALL be w=1 and all enables 0; datapath_in=0.
REQ-018 Reset asserted mid-instruction SHALL abort it; no write or load enable SHALL assert after reset assertion.

Verification
REQ-019 in=0xD007, load=1, s=1 -> DECODE, then WIMM with writenum=0, vsel=1, write=1, datapath_in=0x0007; w=1 on cycle 3.
REQ-020 in=0xD1FE, MOV imm -> datapath_in=0xFFFE, writenum=1 in WIMM.
REQ-021 in=0xA148 (ADD R2,R1,R0 LSL1) -> GETA readnum=1 loada; GETB readnum=0 loadb; EXEC shift=01 ALUop=00 loadc; WRITE writenum=2 write; w after 5 cycles.
REQ-022 in=0xA800 (CMP R0,R0) -> EXEC loads=1, loadc=0, then WAIT with no write pulse.
REQ-023 in=0xC0A8 (MOV R5,R0 LSL1) -> no GETA; EXEC asel=1, ALUop=00, shift=01; WRITE writenum=5.
REQ-024 in=0xE000 (illegal) -> DECODE -> WAIT, all enables 0; plus reset_n pulsed low during GETB of an ADD -> WAIT, no WRITE, w=1 asynchronously.
